// File: rtl/pipereg_elastic.sv
// Elastic in-order pipeline buffer with registered upstream ready and
// selective flush of entries younger than a redirecting ROB index.
module pipereg_elastic #(
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH        = 2,
    parameter int ROBIDX_WIDTH = 7
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [ROBIDX_WIDTH-1:0]   in_robidx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [ROBIDX_WIDTH-1:0]   out_robidx,
    input  logic                      flush_valid,
    input  logic [ROBIDX_WIDTH-1:0]   flush_robidx,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1'b1);

    // Wrap flag differs: the index comparison flips direction.
    function automatic logic f_younger(input logic [ROBIDX_WIDTH-1:0] a,
                                       input logic [ROBIDX_WIDTH-1:0] b);
        if (a[ROBIDX_WIDTH-1] != b[ROBIDX_WIDTH-1]) begin
            f_younger = (a[ROBIDX_WIDTH-2:0] < b[ROBIDX_WIDTH-2:0]);
        end else begin
            f_younger = (a[ROBIDX_WIDTH-2:0] > b[ROBIDX_WIDTH-2:0]);
        end
    endfunction

    logic [DATA_WIDTH-1:0]   r_data   [DEPTH];
    logic [ROBIDX_WIDTH-1:0] r_robidx [DEPTH];
    logic [PW-1:0]           r_rptr;
    logic [PW-1:0]           r_wptr;
    logic [CW-1:0]           r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_deq;
    logic          w_enq;
    logic          w_head_young;
    logic          w_stop;
    logic [PW-1:0] w_slot;
    logic [CW-1:0] w_keep;
    logic [CW-1:0] w_kept;
    logic [CW-1:0] w_count_n;
    logic [PW-1:0] w_rptr_n;
    logic [PW-1:0] w_wptr_n;

    assign w_full       = (r_count == C_DEPTH);
    assign w_empty      = (r_count == {CW{1'b0}});
    assign in_ready     = ~w_full;
    assign out_valid    = ~w_empty;
    assign out_data     = w_empty ? {DATA_WIDTH{1'b0}} : r_data[r_rptr];
    assign out_robidx   = w_empty ? {ROBIDX_WIDTH{1'b0}} : r_robidx[r_rptr];
    assign count        = r_count;
    assign w_head_young = f_younger(r_robidx[r_rptr], flush_robidx);
    assign w_deq        = out_valid & out_ready & ~(flush_valid & w_head_young);
    assign w_enq        = in_valid & in_ready & ~flush_valid;

    // Count the leading run of entries that survive a flush (age-ordered, so the killed ones form the tail).
    always_comb begin
        w_keep = {CW{1'b0}};
        w_stop = 1'b0;
        w_slot = r_rptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = r_rptr + PW'(i);
            if (!w_stop && (CW'(i) < r_count) &&
                !f_younger(r_robidx[w_slot], flush_robidx)) begin
                w_keep = w_keep + C_ONE;
            end else begin
                w_stop = 1'b1;
            end
        end
    end

    // Next pointer/occupancy for normal and flush cycles.
    always_comb begin
        w_kept   = w_keep - CW'(w_deq);
        w_rptr_n = r_rptr + PW'(w_deq);
        if (flush_valid) begin
            w_count_n = w_kept;
            w_wptr_n  = w_rptr_n + w_kept[PW-1:0];
        end else begin
            w_count_n = r_count + CW'(w_enq) - CW'(w_deq);
            w_wptr_n  = r_wptr + PW'(w_enq);
        end
    end

    // State and storage registers; killed slots keep their stale contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rptr  <= {PW{1'b0}};
            r_wptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]   <= {DATA_WIDTH{1'b0}};
                r_robidx[i] <= {ROBIDX_WIDTH{1'b0}};
            end
        end else begin
            r_rptr  <= w_rptr_n;
            r_wptr  <= w_wptr_n;
            r_count <= w_count_n;
            if (w_enq) begin
                r_data[r_wptr]   <= in_data;
                r_robidx[r_wptr] <= in_robidx;
            end
        end
    end

    // Structural invariants of the circular buffer.
    a_no_enq_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(in_valid && in_ready && (r_count == C_DEPTH)));
    a_count_max: assert property (@(posedge clock) disable iff (!reset_n)
        (r_count <= C_DEPTH));
    a_ptr_sync: assert property (@(posedge clock) disable iff (!reset_n)
        (r_wptr == PW'(r_rptr + r_count[PW-1:0])));

endmodule

// File: tb/tb_pipereg_elastic.sv
// Bench for pipereg_elastic: DEPTH=2 and DEPTH=4 instances share stimulus,
// each checked against a queue-based model.
module tb_pipereg_elastic;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic [6:0]  in_robidx = 7'd0;
    logic        out_ready = 1'b0;
    logic        flush_valid = 1'b0;
    logic [6:0]  flush_robidx = 7'd0;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [6:0]  a_out_robidx, b_out_robidx;
    logic [1:0]  a_count;
    logic [2:0]  b_count;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [38:0] q2[$];
    logic [38:0] q4[$];
    logic [6:0]  rob_ctr = 7'd0;

    always #5 clock = ~clock;

    pipereg_elastic #(.DATA_WIDTH(32), .DEPTH(2), .ROBIDX_WIDTH(7)) u_d2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_robidx(in_robidx),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_robidx(a_out_robidx),
        .flush_valid(flush_valid), .flush_robidx(flush_robidx), .count(a_count));

    pipereg_elastic #(.DATA_WIDTH(32), .DEPTH(4), .ROBIDX_WIDTH(7)) u_d4 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_robidx(in_robidx),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_robidx(b_out_robidx),
        .flush_valid(flush_valid), .flush_robidx(flush_robidx), .count(b_count));

    function automatic logic younger(input logic [6:0] a, input logic [6:0] b);
        int ai = int'(a[5:0]);
        int bi = int'(b[5:0]);
        if (a[6] != b[6]) return ai < bi;
        return ai > bi;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [38:0] q[$];
        int dep;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin q = q2; dep = 2; end
            else begin q = q4; dep = 4; end
            check_eq($sformatf("d%0d_valid", dep), (k == 0) ? 64'(a_out_valid) : 64'(b_out_valid), 64'(q.size() != 0));
            check_eq($sformatf("d%0d_ready", dep), (k == 0) ? 64'(a_in_ready) : 64'(b_in_ready), 64'(q.size() != dep));
            check_eq($sformatf("d%0d_count", dep), (k == 0) ? 64'(a_count) : 64'(b_count), 64'(q.size()));
            check_eq($sformatf("d%0d_data", dep), (k == 0) ? 64'(a_out_data) : 64'(b_out_data),
                     (q.size() != 0) ? 64'(q[0][31:0]) : 64'd0);
            check_eq($sformatf("d%0d_robidx", dep), (k == 0) ? 64'(a_out_robidx) : 64'(b_out_robidx),
                     (q.size() != 0) ? 64'(q[0][38:32]) : 64'd0);
        end
    endtask

    task automatic model_update();
        logic [38:0] q[$];
        int dep;
        int sz;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin q = q2; dep = 2; end
            else begin q = q4; dep = 4; end
            sz = q.size();
            if (flush_valid) begin
                if (out_ready && sz > 0 && !younger(q[0][38:32], flush_robidx)) void'(q.pop_front());
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (younger(q[i][38:32], flush_robidx)) q.delete(i);
                end
            end else begin
                if (out_ready && sz > 0) void'(q.pop_front());
                if (in_valid && sz != dep) q.push_back({in_robidx, in_data});
            end
            if (k == 0) q2 = q;
            else q4 = q;
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] d, input logic [6:0] r,
                        input logic ordy, input logic fv, input logic [6:0] fr);
        in_valid = iv; in_data = d; in_robidx = r;
        out_ready = ordy; flush_valid = fv; flush_robidx = fr;
        @(negedge clock);
        check_all();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic ordy);
        step(1'b1, d, rob_ctr, ordy, 1'b0, 7'd0);
        rob_ctr = rob_ctr + 7'd1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush_valid = 1'b0;
        q2.delete(); q4.delete();
        @(negedge clock);
        check_all();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic iv, ordy, fv, acc;
        logic [6:0] fr;

        // Reset state
        do_reset();
        check_eq("rst_in_ready", 64'(b_in_ready), 64'd1);

        // Streaming with out_ready held high
        for (int i = 1; i <= 8; i++) push(32'(i), 1'b1);
        check_eq("stream_cnt", 64'(a_count), 64'd1);
        step(1'b0, 32'd0, 7'd0, 1'b1, 1'b0, 7'd0);

        // Backpressure
        do_reset();
        push(32'hA, 1'b0);
        push(32'hB, 1'b0);
        push(32'hC, 1'b0);
        check_eq("bp_cnt", 64'(a_count), 64'd2);
        check_eq("bp_ready", 64'(a_in_ready), 64'd0);
        check_eq("bp_head", 64'(a_out_data), 64'hA);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 7'd0, 1'b1, 1'b0, 7'd0);

        // Selective flush keeps the entry equal to flush_robidx
        do_reset();
        rob_ctr = 7'd5;
        for (int i = 0; i < 3; i++) push(32'h100 + 32'(i), 1'b0);
        step(1'b0, 32'd0, 7'd0, 1'b0, 1'b1, 7'd5);
        check_eq("fl_cnt", 64'(b_count), 64'd1);
        check_eq("fl_head", 64'(b_out_robidx), 64'd5);

        do_reset();
        rob_ctr = 7'd5;
        for (int i = 0; i < 3; i++) push(32'h200 + 32'(i), 1'b0);
        step(1'b0, 32'd0, 7'd0, 1'b0, 1'b1, 7'd4);
        check_eq("fl_all_valid", 64'(b_out_valid), 64'd0);

        // Flag wrap: flag1:63, flag0:0, flag0:1 are all younger than flag1:62
        do_reset();
        rob_ctr = 7'h7F;
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(i), 1'b0);
        step(1'b0, 32'd0, 7'd0, 1'b0, 1'b1, 7'h7E);
        check_eq("fl_wrap_valid", 64'(b_out_valid), 64'd0);
        step(1'b0, 32'd0, 7'd0, 1'b0, 1'b0, 7'd0);

        // Flush with same-cycle dequeue and a dropped incoming entry
        do_reset();
        rob_ctr = 7'd10;
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(i), 1'b0);
        step(1'b1, 32'hDEAD, 7'd13, 1'b1, 1'b1, 7'd10);
        check_eq("flpop_cnt4", 64'(b_count), 64'd0);
        check_eq("flpop_cnt2", 64'(a_count), 64'd0);
        step(1'b0, 32'd0, 7'd0, 1'b1, 1'b0, 7'd0);

        // Pointer wrap with random backpressure
        do_reset();
        for (int c = 0; c < 60; c++) begin
            iv = (c < 11);
            ordy = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            step(iv, $urandom, rob_ctr, ordy, 1'b0, 7'd0);
            if (iv) rob_ctr = rob_ctr + 7'd1;
        end
        check_eq("wrap_cnt2", 64'(a_count), 64'd0);
        check_eq("wrap_cnt4", 64'(b_count), 64'd0);

        // Random traffic with flushes and occasional mid-operation reset
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            iv   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            fv   = ($urandom_range(0, 7) == 0);
            if (q4.size() != 0) fr = q4[$urandom_range(0, q4.size() - 1)][38:32] - 7'($urandom_range(0, 1));
            else fr = rob_ctr - 7'd1;
            acc = iv && !fv && (q2.size() != 2 || q4.size() != 4);
            step(iv, $urandom, rob_ctr, ordy, fv, fr);
            if (acc) rob_ctr = rob_ctr + 7'd1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
